// File: rtl/menu_screen_renderer.sv
// ============================================================================
// Module      : menu_screen_renderer
// Description : N-item vertical button menu for the 96x64 OLED. Includes a
//               cursor FSM, highlight blink and confirm flash. The selection
//               is reported to the game FSM. Optional cursor wrap-around is
//               enabled by defining MENU_WRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module menu_screen_renderer #(
    parameter int          N_ITEMS        = 3,
    parameter int          BOX_X0         = 43,
    parameter int          BOX_W          = 11,
    parameter int          ITEM_Y0        = 18,
    parameter int          ITEM_H         = 9,
    parameter int          ITEM_PITCH     = 11,
    parameter int          BLINK_FRAMES   = 16,
    parameter int          CONFIRM_FRAMES = 8,
    parameter logic [15:0] FG             = 16'hFFFF,
    parameter logic [15:0] HL             = 16'h07E0,
    parameter logic [15:0] BG             = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  x,
    input  logic [5:0]  y,
    input  logic        frame_tick,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_sel,
    output logic [15:0] oled_data,
    output logic [2:0]  cursor,
    output logic        sel_valid,
    output logic [2:0]  sel_index,
    output logic        busy
);

    localparam logic [1:0] S_NAV     = 2'd0;
    localparam logic [1:0] S_CONFIRM = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic [2:0] c_last_item  = 3'(N_ITEMS - 1);
    localparam logic [7:0] c_blink_last = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] c_conf_last  = 8'(CONFIRM_FRAMES - 1);
    localparam logic [9:0] c_x_lo       = 10'(BOX_X0);
    localparam logic [9:0] c_x_hi       = 10'(BOX_X0 + BOX_W - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [2:0]  r_cursor;
    logic [2:0]  w_cursor_nxt;
    logic        r_phase;
    logic [7:0]  r_blink_cnt;
    logic [7:0]  r_conf_cnt;
    logic [2:0]  r_sel_index;
    logic [15:0] r_oled;
    logic [15:0] w_pix;
    logic        w_fill;
    logic        w_up;
    logic        w_down;
    logic        w_move;
    logic        w_sel_done;
    logic [9:0]  w_x10;
    logic [9:0]  w_y10;
    logic [7:0]  w_edge;
    logic [7:0]  w_inner;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_NAV;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_sel_done = (r_state == S_CONFIRM) && frame_tick && (r_conf_cnt == c_conf_last);

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_NAV:     if (btn_sel) w_state_nxt = S_CONFIRM;
            S_CONFIRM: if (w_sel_done) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_NAV;
            default:   w_state_nxt = S_NAV;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (r_state == S_CONFIRM);
        sel_valid = (r_state == S_DONE);
    end

    // Select beats any same-cycle direction press, and opposing presses cancel.
    assign w_up   = (r_state == S_NAV) && btn_up && !btn_down && !btn_sel;
    assign w_down = (r_state == S_NAV) && btn_down && !btn_up && !btn_sel;

    always_comb begin
        w_cursor_nxt = r_cursor;
        if (w_up) begin
`ifdef MENU_WRAP_EN
            w_cursor_nxt = (r_cursor == 3'd0) ? c_last_item : r_cursor - 3'd1;
`else
            if (r_cursor != 3'd0) w_cursor_nxt = r_cursor - 3'd1;
`endif
        end else if (w_down) begin
`ifdef MENU_WRAP_EN
            w_cursor_nxt = (r_cursor == c_last_item) ? 3'd0 : r_cursor + 3'd1;
`else
            if (r_cursor != c_last_item) w_cursor_nxt = r_cursor + 3'd1;
`endif
        end
    end

    // A blocked press at a saturated edge is not a move and keeps the blink state.
    assign w_move = (w_cursor_nxt != r_cursor);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cursor    <= 3'd0;
            r_phase     <= 1'b1;
            r_blink_cnt <= 8'd0;
            r_conf_cnt  <= 8'd0;
            r_sel_index <= 3'd0;
            r_oled      <= 16'd0;
        end else begin
            r_cursor <= w_cursor_nxt;
            r_oled   <= w_pix;

            if (r_state == S_NAV) begin
                if (w_move) begin
                    r_phase     <= 1'b1;
                    r_blink_cnt <= 8'd0;
                end else if (frame_tick) begin
                    if (r_blink_cnt == c_blink_last) begin
                        r_blink_cnt <= 8'd0;
                        r_phase     <= ~r_phase;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + 8'd1;
                    end
                end
            end

            if ((r_state == S_NAV) && btn_sel) begin
                r_conf_cnt <= 8'd0;
            end else if ((r_state == S_CONFIRM) && frame_tick) begin
                r_conf_cnt <= r_conf_cnt + 8'd1;
            end

            if (w_sel_done) r_sel_index <= r_cursor;
        end
    end

    // ------------------------------------------------------------------
    // Pixel path: box hit tests, widened so item tops never wrap
    // ------------------------------------------------------------------
    assign w_x10 = {3'd0, x};
    assign w_y10 = {4'd0, y};

    for (genvar gi = 0; gi < 8; gi++) begin : g_item
        if (gi < N_ITEMS) begin : g_live
            localparam logic [9:0] c_top = 10'(ITEM_Y0 + gi * ITEM_PITCH);
            localparam logic [9:0] c_bot = 10'(ITEM_Y0 + gi * ITEM_PITCH + ITEM_H - 1);
            logic w_hit;
            logic w_rim;
            assign w_hit = (w_x10 >= c_x_lo) && (w_x10 <= c_x_hi) &&
                           (w_y10 >= c_top) && (w_y10 <= c_bot);
            assign w_rim = (w_x10 == c_x_lo) || (w_x10 == c_x_hi) ||
                           (w_y10 == c_top) || (w_y10 == c_bot);
            assign w_edge[gi]  = w_hit && w_rim;
            assign w_inner[gi] = w_hit && !w_rim;
        end else begin : g_pad
            assign w_edge[gi]  = 1'b0;
            assign w_inner[gi] = 1'b0;
        end
    end

    // DONE lasts one cycle and shows the ordinary blink state.
    assign w_fill = (r_state == S_CONFIRM) ? ~r_conf_cnt[0] : r_phase;

    always_comb begin
        w_pix = BG;
        if (|w_edge) begin
            w_pix = FG;
        end else if (w_inner[r_cursor] && w_fill) begin
            w_pix = HL;
        end
    end

    assign oled_data = r_oled;
    assign cursor    = r_cursor;
    assign sel_index = r_sel_index;

endmodule

`default_nettype wire

// File: tb/tb_menu_screen_renderer.sv
// ============================================================================
// Module      : tb_menu_screen_renderer
// Description : Self-checking bench for menu_screen_renderer. It runs directed
//               scenarios and then randomized traffic. A behavioural menu model
//               is checked against the DUT on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_menu_screen_renderer;

    localparam int          N_ITEMS        = 3;
    localparam int          BOX_X0         = 43;
    localparam int          BOX_W          = 11;
    localparam int          ITEM_Y0        = 18;
    localparam int          ITEM_H         = 9;
    localparam int          ITEM_PITCH     = 11;
    localparam int          BLINK_FRAMES   = 16;
    localparam int          CONFIRM_FRAMES = 8;
    localparam logic [15:0] FG             = 16'hFFFF;
    localparam logic [15:0] HL             = 16'h07E0;
    localparam logic [15:0] BG             = 16'h0000;

`ifdef MENU_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  x;
    logic [5:0]  y;
    logic        frame_tick;
    logic        btn_up;
    logic        btn_down;
    logic        btn_sel;
    logic [15:0] oled_data;
    logic [2:0]  cursor;
    logic        sel_valid;
    logic [2:0]  sel_index;
    logic        busy;

    menu_screen_renderer #(
        .N_ITEMS(N_ITEMS), .BOX_X0(BOX_X0), .BOX_W(BOX_W), .ITEM_Y0(ITEM_Y0),
        .ITEM_H(ITEM_H), .ITEM_PITCH(ITEM_PITCH), .BLINK_FRAMES(BLINK_FRAMES),
        .CONFIRM_FRAMES(CONFIRM_FRAMES), .FG(FG), .HL(HL), .BG(BG)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
        .oled_data(oled_data), .cursor(cursor), .sel_valid(sel_valid),
        .sel_index(sel_index), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit sv_seen = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: 0 = navigating, 1 = confirming, 2 = done
    int          m_state, m_cur, m_phase, m_bcnt, m_ccnt, m_sel;
    logic [15:0] m_oled;
    bit          m_valid = 1'b0;

    function automatic logic [15:0] pix(input int px, input int py, input int cur, input bit fill);
        for (int i = 0; i < N_ITEMS; i++) begin
            int top = ITEM_Y0 + i * ITEM_PITCH;
            int bot = top + ITEM_H - 1;
            int rgt = BOX_X0 + BOX_W - 1;
            if (px >= BOX_X0 && px <= rgt && py >= top && py <= bot) begin
                if (px == BOX_X0 || px == rgt || py == top || py == bot) return FG;
                return (i == cur && fill) ? HL : BG;
            end
        end
        return BG;
    endfunction

    task automatic model_step();
        int target;
        if (reset) begin
            m_state = 0; m_cur = 0; m_phase = 1; m_bcnt = 0; m_ccnt = 0;
            m_sel = 0; m_oled = 16'h0000; m_valid = 1'b1;
            return;
        end
        m_oled = pix(int'(x), int'(y), m_cur, (m_state == 1) ? (m_ccnt % 2 == 0) : (m_phase == 1));
        case (m_state)
            0: begin
                if (frame_tick) begin
                    m_bcnt++;
                    if (m_bcnt == BLINK_FRAMES) begin
                        m_bcnt  = 0;
                        m_phase = 1 - m_phase;
                    end
                end
                if (btn_sel) begin
                    m_state = 1;
                    m_ccnt  = 0;
                end else if (btn_up != btn_down) begin
                    target = btn_up ? m_cur - 1 : m_cur + 1;
                    if (WRAP) target = (target + N_ITEMS) % N_ITEMS;
                    else if (target < 0) target = 0;
                    else if (target > N_ITEMS - 1) target = N_ITEMS - 1;
                    if (target != m_cur) begin
                        m_cur = target; m_phase = 1; m_bcnt = 0;
                    end
                end
            end
            1: begin
                if (frame_tick) begin
                    if (m_ccnt == CONFIRM_FRAMES - 1) begin
                        m_state = 2;
                        m_sel   = m_cur;
                    end else begin
                        m_ccnt++;
                    end
                end
            end
            default: m_state = 0;
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (sel_valid === 1'b1) sv_seen = 1'b1;
        if (m_valid) begin
            chk("model_oled", oled_data, m_oled);
            chk("model_cursor", {13'd0, cursor}, 16'(m_cur));
            chk("model_busy", {15'd0, busy}, {15'd0, m_state == 1});
            chk("model_sel_valid", {15'd0, sel_valid}, {15'd0, m_state == 2});
            chk("model_sel_index", {13'd0, sel_index}, 16'(m_sel));
        end
    end

    task automatic cyc(input bit u, input bit d, input bit s, input bit t);
        btn_up = u; btn_down = d; btn_sel = s; frame_tick = t;
        @(negedge clk);
        btn_up = 0; btn_down = 0; btn_sel = 0; frame_tick = 0;
    endtask

    initial begin
        reset = 1; x = 0; y = 0;
        btn_up = 0; btn_down = 0; btn_sel = 0; frame_tick = 0;
        @(negedge clk);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        reset = 0;
        chk("rst_oled", oled_data, 16'h0000);
        chk("rst_cursor", {13'd0, cursor}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_sel_valid", {15'd0, sel_valid}, 16'd0);
        chk("rst_sel_index", {13'd0, sel_index}, 16'd0);

        x = 43; y = 18; cyc(0, 0, 0, 0);
        chk("corner_fg", oled_data, 16'hFFFF);
        x = 48; y = 22; cyc(0, 0, 0, 0);
        chk("item0_hl", oled_data, 16'h07E0);
        x = 10; y = 10; cyc(0, 0, 0, 0);
        chk("outside_bg", oled_data, 16'h0000);

        x = 48; y = 22;
        repeat (16) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("blink_off", oled_data, 16'h0000);
        repeat (16) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("blink_on", oled_data, 16'h07E0);

        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("down_twice", {13'd0, cursor}, 16'd2);
        cyc(0, 1, 0, 0);
        chk("down_at_edge", {13'd0, cursor}, WRAP ? 16'd0 : 16'd2);
        x = 48; y = 44; cyc(0, 0, 0, 0);
        chk("item2_fill", oled_data, WRAP ? 16'h0000 : 16'h07E0);

        cyc(1, 1, 0, 0);
        chk("up_down_cancel", {13'd0, cursor}, WRAP ? 16'd0 : 16'd2);
        if (WRAP) cyc(0, 1, 0, 0);
        else      cyc(1, 0, 0, 0);
        chk("cursor_to_1", {13'd0, cursor}, 16'd1);

        x = 48; y = 33;
        cyc(0, 1, 1, 0);
        chk("sel_beats_down", {13'd0, cursor}, 16'd1);
        chk("sel_busy", {15'd0, busy}, 16'd1);
        for (int k = 0; k < 8; k++) begin
            cyc(k == 2, k == 3, k == 4, 1);
            chk("conf_flash", oled_data, (k % 2 == 0) ? 16'h07E0 : 16'h0000);
            if (k == 6) chk("no_early_valid", {15'd0, sel_valid}, 16'd0);
        end
        chk("sel_valid_pulse", {15'd0, sel_valid}, 16'd1);
        chk("sel_index_1", {13'd0, sel_index}, 16'd1);
        chk("busy_cleared", {15'd0, busy}, 16'd0);
        cyc(0, 0, 0, 0);
        chk("sel_valid_one_cycle", {15'd0, sel_valid}, 16'd0);
        chk("sel_index_held", {13'd0, sel_index}, 16'd1);

        cyc(0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 1);
        chk("mid_confirm_busy", {15'd0, busy}, 16'd1);
        reset = 1; cyc(0, 0, 0, 0); reset = 0;
        chk("reset_cursor", {13'd0, cursor}, 16'd0);
        chk("reset_busy", {15'd0, busy}, 16'd0);
        sv_seen = 1'b0;
        repeat (20) begin
            cyc(0, 0, 0, 1);
            cyc(0, 0, 0, 0);
        end
        chk("no_sel_after_reset", {15'd0, sv_seen}, 16'd0);

        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 1) == 0) begin
                x = 7'($urandom_range(40, 56));
                y = 6'($urandom_range(14, 63));
            end else begin
                x = 7'($urandom_range(0, 95));
                y = 6'($urandom_range(0, 63));
            end
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0);
        end
        reset = 0;
        cyc(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
